// File: rtl/reg_cmd_pkg.sv
// Shared definitions for the register-file command controller: state
// encoding, default opcodes and the frame/word width relationship.
package reg_cmd_pkg;

  localparam int unsigned STATE_W = 4;

  localparam logic [STATE_W-1:0] S_IDLE    = 4'd0;
  localparam logic [STATE_W-1:0] S_WR_ADDR = 4'd1;
  localparam logic [STATE_W-1:0] S_WR_LO   = 4'd2;
  localparam logic [STATE_W-1:0] S_WR_HI   = 4'd3;
  localparam logic [STATE_W-1:0] S_RD_ADDR = 4'd4;
  localparam logic [STATE_W-1:0] S_RD_REQ  = 4'd5;
  localparam logic [STATE_W-1:0] S_RD_CAP  = 4'd6;
  localparam logic [STATE_W-1:0] S_TX_LO   = 4'd7;
  localparam logic [STATE_W-1:0] S_TX_HI   = 4'd8;

  localparam int DEF_DATA_WIDTH = 8;
  localparam int DEF_REG_WIDTH  = 16;
  localparam int DEF_ADDR_WIDTH = 3;

  localparam logic [7:0] DEF_WR_CMD = 8'hAA;
  localparam logic [7:0] DEF_RD_CMD = 8'hBB;

  // A register word is always carried as exactly two frame bytes.
  function automatic bit widths_ok(input int data_w, input int reg_w);
    return reg_w == 2 * data_w;
  endfunction

endpackage

// File: rtl/reg_cmd_ctrl.sv
// Byte-stream command parser and sole master of the 16-bit register file.
// Write frame: WR_CMD, ADDR, DATA_LO, DATA_HI.
// Read frame : RD_CMD, ADDR -> two TX bytes, low byte first.
//
// state     | meaning
// ----------+------------------------------------------------
// IDLE      | waiting for an opcode byte
// WR_ADDR   | write: waiting for address byte
// WR_LO     | write: waiting for low data byte
// WR_HI     | write: waiting for high data byte
// RD_ADDR   | read: waiting for address byte
// RD_REQ    | read: REG_RdEn high for this cycle
// RD_CAP    | read: register file data valid, capture it
// TX_LO     | presenting low byte until accepted
// TX_HI     | presenting high byte until accepted
module reg_cmd_ctrl
  import reg_cmd_pkg::*;
#(
  parameter int DATA_WIDTH = DEF_DATA_WIDTH,
  parameter int REG_WIDTH  = DEF_REG_WIDTH,
  parameter int ADDR_WIDTH = DEF_ADDR_WIDTH,
  parameter logic [DATA_WIDTH-1:0] WR_CMD = DEF_WR_CMD,
  parameter logic [DATA_WIDTH-1:0] RD_CMD = DEF_RD_CMD
) (
  input  logic                  CLK,
  input  logic                  RST,
  input  logic [DATA_WIDTH-1:0] RX_DATA,
  input  logic                  RX_VLD,
  output logic                  REG_WrEn,
  output logic                  REG_RdEn,
  output logic [ADDR_WIDTH-1:0] REG_Address,
  output logic [REG_WIDTH-1:0]  REG_WrData,
  input  logic [REG_WIDTH-1:0]  REG_RdData,
  output logic [DATA_WIDTH-1:0] TX_DATA,
  output logic                  TX_VLD,
  input  logic                  TX_RDY,
  output logic                  BUSY,
  output logic                  CMD_ERR
);

  if (!widths_ok(DATA_WIDTH, REG_WIDTH)) begin : g_bad_width
    $error("reg_cmd_ctrl: REG_WIDTH must be twice DATA_WIDTH");
  end

  logic [STATE_W-1:0] state;
  logic [REG_WIDTH-1:0] rd_buf;

  // Frame parser, register-file strobes and TX handshake; all outputs registered.
  always_ff @(posedge CLK or negedge RST) begin
    if (!RST) begin
      state       <= S_IDLE;
      rd_buf      <= '0;
      REG_WrEn    <= 1'b0;
      REG_RdEn    <= 1'b0;
      REG_Address <= '0;
      REG_WrData  <= '0;
      TX_DATA     <= '0;
      TX_VLD      <= 1'b0;
      BUSY        <= 1'b0;
      CMD_ERR     <= 1'b0;
    end else begin
      REG_WrEn <= 1'b0;
      REG_RdEn <= 1'b0;
      CMD_ERR  <= 1'b0;
      case (state)
        S_IDLE: begin
          if (RX_VLD) begin
            if (RX_DATA == WR_CMD) begin
              state <= S_WR_ADDR;
              BUSY  <= 1'b1;
            end else if (RX_DATA == RD_CMD) begin
              state <= S_RD_ADDR;
              BUSY  <= 1'b1;
            end else begin
              CMD_ERR <= 1'b1;
            end
          end
        end
        S_WR_ADDR: begin
          if (RX_VLD) begin
            REG_Address <= RX_DATA[ADDR_WIDTH-1:0];
            state       <= S_WR_LO;
          end
        end
        S_WR_LO: begin
          if (RX_VLD) begin
            REG_WrData[DATA_WIDTH-1:0] <= RX_DATA;
            state                      <= S_WR_HI;
          end
        end
        S_WR_HI: begin
          if (RX_VLD) begin
            REG_WrData[REG_WIDTH-1:DATA_WIDTH] <= RX_DATA;
            REG_WrEn                           <= 1'b1;
            state                              <= S_IDLE;
            BUSY                               <= 1'b0;
          end
        end
        S_RD_ADDR: begin
          if (RX_VLD) begin
            REG_Address <= RX_DATA[ADDR_WIDTH-1:0];
            REG_RdEn    <= 1'b1;
            state       <= S_RD_REQ;
          end
        end
        S_RD_REQ: begin
          CMD_ERR <= RX_VLD;
          state   <= S_RD_CAP;
        end
        S_RD_CAP: begin
          // Read data is taken straight from the bus so the low byte needs no extra cycle.
          CMD_ERR <= RX_VLD;
          rd_buf  <= REG_RdData;
          TX_DATA <= REG_RdData[DATA_WIDTH-1:0];
          TX_VLD  <= 1'b1;
          state   <= S_TX_LO;
        end
        S_TX_LO: begin
          CMD_ERR <= RX_VLD;
          if (TX_RDY) begin
            TX_DATA <= rd_buf[REG_WIDTH-1:DATA_WIDTH];
            state   <= S_TX_HI;
          end
        end
        S_TX_HI: begin
          CMD_ERR <= RX_VLD;
          if (TX_RDY) begin
            TX_VLD <= 1'b0;
            state  <= S_IDLE;
            BUSY   <= 1'b0;
          end
        end
        default: begin
          state  <= S_IDLE;
          TX_VLD <= 1'b0;
          BUSY   <= 1'b0;
        end
      endcase
    end
  end

endmodule

// File: tb/tb_reg_cmd_ctrl.sv
// Bench for reg_cmd_ctrl: directed frames with cycle-exact checks, then
// random frames checked against a transaction-level model (memory image,
// expected write / read-address / TX-byte queues, CMD_ERR count).
module tb_reg_cmd_ctrl;

  logic        CLK = 1'b0;
  logic        RST;
  logic [7:0]  RX_DATA;
  logic        RX_VLD;
  logic        REG_WrEn;
  logic        REG_RdEn;
  logic [2:0]  REG_Address;
  logic [15:0] REG_WrData;
  logic [15:0] REG_RdData;
  logic [7:0]  TX_DATA;
  logic        TX_VLD;
  logic        TX_RDY;
  logic        BUSY;
  logic        CMD_ERR;

  int n_cmp = 0;
  int n_bad = 0;

  // model state
  logic [15:0] model_mem [8];
  logic [15:0] rf_mem [8];
  logic [18:0] exp_wr_q [$];
  logic [2:0]  exp_rd_q [$];
  logic [7:0]  exp_tx_q [$];
  int exp_err = 0;
  int obs_err = 0;

  reg_cmd_ctrl dut (
    .CLK(CLK), .RST(RST), .RX_DATA(RX_DATA), .RX_VLD(RX_VLD),
    .REG_WrEn(REG_WrEn), .REG_RdEn(REG_RdEn), .REG_Address(REG_Address),
    .REG_WrData(REG_WrData), .REG_RdData(REG_RdData),
    .TX_DATA(TX_DATA), .TX_VLD(TX_VLD), .TX_RDY(TX_RDY),
    .BUSY(BUSY), .CMD_ERR(CMD_ERR)
  );

  always #5 CLK = ~CLK;

  // Register file stand-in: synchronous write, read data one cycle after RdEn.
  always @(posedge CLK) begin
    if (REG_WrEn) rf_mem[REG_Address] <= REG_WrData;
    if (REG_RdEn) REG_RdData <= rf_mem[REG_Address];
  end

  task automatic check_val(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_cmp++;
    if (obs !== exp) begin
      n_bad++;
      $display("FAIL %s: observed %h expected %h", tag, obs, exp);
    end
  endtask

  // Transaction monitor, sampled mid-cycle.
  always @(negedge CLK) begin
    if (RST) begin
      if (CMD_ERR) obs_err++;
      if (REG_WrEn || REG_RdEn)
        check_val("wr_rd_exclusive", {31'd0, REG_WrEn & REG_RdEn}, 32'd0);
      if (REG_WrEn) begin
        check_val("wr_expected", {31'd0, exp_wr_q.size() > 0}, 32'd1);
        if (exp_wr_q.size() > 0)
          check_val("wr_addr_data", {13'd0, REG_Address, REG_WrData}, {13'd0, exp_wr_q.pop_front()});
      end
      if (REG_RdEn) begin
        check_val("rd_expected", {31'd0, exp_rd_q.size() > 0}, 32'd1);
        if (exp_rd_q.size() > 0)
          check_val("rd_addr", {29'd0, REG_Address}, {29'd0, exp_rd_q.pop_front()});
      end
      if (TX_VLD && TX_RDY) begin
        check_val("tx_expected", {31'd0, exp_tx_q.size() > 0}, 32'd1);
        if (exp_tx_q.size() > 0)
          check_val("tx_byte", {24'd0, TX_DATA}, {24'd0, exp_tx_q.pop_front()});
      end
    end
  end

  task automatic to_drv();
    @(posedge CLK);
    #1;
  endtask

  // Called at posedge+1; returns at posedge+1 just after the byte is accepted.
  task automatic send_byte(input logic [7:0] b);
    RX_DATA = b;
    RX_VLD  = 1'b1;
    to_drv();
    RX_VLD  = 1'b0;
  endtask

  task automatic idle_cycles(input int n);
    repeat (n) to_drv();
  endtask

  function automatic logic [31:0] all_outs();
    return {REG_WrEn, REG_RdEn, REG_Address, REG_WrData, TX_DATA, TX_VLD, BUSY, CMD_ERR};
  endfunction

  task automatic wr_frame(input logic [7:0] a, input logic [7:0] lo, input logic [7:0] hi, input int max_gap);
    exp_wr_q.push_back({a[2:0], hi, lo});
    model_mem[a[2:0]] = {hi, lo};
    send_byte(8'hAA); idle_cycles($urandom_range(0, max_gap));
    send_byte(a);     idle_cycles($urandom_range(0, max_gap));
    send_byte(lo);    idle_cycles($urandom_range(0, max_gap));
    send_byte(hi);
  endtask

  task automatic rd_frame(input logic [7:0] a, input bit inject);
    bit done = 0;
    exp_rd_q.push_back(a[2:0]);
    exp_tx_q.push_back(model_mem[a[2:0]][7:0]);
    exp_tx_q.push_back(model_mem[a[2:0]][15:8]);
    send_byte(8'hBB);
    send_byte(a);
    if (inject) begin
      exp_err++;
      send_byte(8'(($urandom_range(0, 255))));
    end
    for (int c = 0; c < 300 && !done; c++) begin
      TX_RDY = ($urandom_range(0, 9) < 6);
      @(negedge CLK);
      if (!BUSY) done = 1;
      to_drv();
    end
    TX_RDY = 1'b1;
    check_val("rd_done_in_time", {31'd0, done}, 32'd1);
  endtask

  initial begin
    #400000;
    $display("FAIL watchdog: observed timeout expected completion");
    $fatal(1, "watchdog");
  end

  initial begin
    logic [7:0] b;
    for (int i = 0; i < 8; i++) begin
      model_mem[i] = '0;
      rf_mem[i]    = '0;
    end
    REG_RdData = '0;
    RST = 1'b0; RX_VLD = 1'b0; RX_DATA = '0; TX_RDY = 1'b1;
    #12;
    check_val("reset_outputs", all_outs(), 32'd0);
    @(negedge CLK); RST = 1'b1;
    to_drv();

    // write AA,05,07,00 back to back
    exp_wr_q.push_back({3'd5, 16'h0007});
    model_mem[5] = 16'h0007;
    send_byte(8'hAA);
    @(negedge CLK); check_val("busy_after_opcode", {31'd0, BUSY}, 32'd1);
    to_drv();
    send_byte(8'h05);
    send_byte(8'h07);
    @(negedge CLK); check_val("busy_wr_hi", {31'd0, BUSY}, 32'd1);
    to_drv();
    send_byte(8'h00);
    @(negedge CLK);
    check_val("wren_pulse", {31'd0, REG_WrEn}, 32'd1);
    check_val("wr_address", {29'd0, REG_Address}, 32'd5);
    check_val("wr_data", {16'd0, REG_WrData}, 32'h0007);
    check_val("busy_wren_cycle", {31'd0, BUSY}, 32'd0);
    @(negedge CLK); check_val("wren_one_cycle", {31'd0, REG_WrEn}, 32'd0);
    to_drv();

    // read BB,05 with TX_RDY=1: latency and consecutive bytes
    exp_rd_q.push_back(3'd5);
    exp_tx_q.push_back(8'h07);
    exp_tx_q.push_back(8'h00);
    send_byte(8'hBB);
    send_byte(8'h05);
    @(negedge CLK);
    check_val("rden_k1", {31'd0, REG_RdEn}, 32'd1);
    check_val("txvld_k1", {31'd0, TX_VLD}, 32'd0);
    @(negedge CLK);
    check_val("rden_k2", {31'd0, REG_RdEn}, 32'd0);
    check_val("txvld_k2", {31'd0, TX_VLD}, 32'd0);
    @(negedge CLK);
    check_val("tx_k3", {23'd0, TX_VLD, TX_DATA}, {23'd0, 1'b1, 8'h07});
    @(negedge CLK);
    check_val("tx_k4", {23'd0, TX_VLD, TX_DATA}, {23'd0, 1'b1, 8'h00});
    @(negedge CLK);
    check_val("tx_k5_done", {30'd0, TX_VLD, BUSY}, 32'd0);
    to_drv();

    // write AA,07,0F,A5 then stalled read with a dropped byte
    wr_frame(8'h07, 8'h0F, 8'hA5, 0);
    to_drv();
    TX_RDY = 1'b0;
    exp_rd_q.push_back(3'd7);
    exp_tx_q.push_back(8'h0F);
    exp_tx_q.push_back(8'hA5);
    send_byte(8'hBB);
    send_byte(8'h07);
    repeat (3) @(negedge CLK);
    check_val("stall_first", {23'd0, TX_VLD, TX_DATA}, {23'd0, 1'b1, 8'h0F});
    for (int i = 0; i < 4; i++) begin
      @(negedge CLK);
      check_val("stall_hold", {22'd0, BUSY, TX_VLD, TX_DATA}, {22'd0, 2'b11, 8'h0F});
    end
    to_drv();
    exp_err++;
    send_byte(8'h55);
    @(negedge CLK);
    check_val("drop_cmd_err", {31'd0, CMD_ERR}, 32'd1);
    check_val("drop_tx_hold", {23'd0, TX_VLD, TX_DATA}, {23'd0, 1'b1, 8'h0F});
    to_drv();
    TX_RDY = 1'b1;
    @(negedge CLK);
    check_val("release_lo", {23'd0, TX_VLD, TX_DATA}, {23'd0, 1'b1, 8'h0F});
    @(negedge CLK);
    check_val("release_hi", {23'd0, TX_VLD, TX_DATA}, {23'd0, 1'b1, 8'hA5});
    @(negedge CLK);
    check_val("release_idle", {30'd0, TX_VLD, BUSY}, 32'd0);
    to_drv();

    // unknown opcode in IDLE
    exp_err++;
    send_byte(8'h3C);
    @(negedge CLK);
    check_val("bad_opcode", {28'd0, CMD_ERR, REG_WrEn, REG_RdEn, BUSY}, {28'd0, 4'b1000});
    @(negedge CLK);
    check_val("bad_opcode_pulse", {31'd0, CMD_ERR}, 32'd0);
    to_drv();
    wr_frame(8'hF3, 8'h5A, 8'hC3, 1);
    to_drv();
    rd_frame(8'h03, 1'b0);

    // async reset mid-frame
    send_byte(8'hAA);
    send_byte(8'h02);
    #2;
    RST = 1'b0;
    #1;
    check_val("async_reset", all_outs(), 32'd0);
    @(negedge CLK); RST = 1'b1;
    to_drv();
    for (int i = 1; i <= 3; i++) begin
      exp_err++;
      send_byte(8'(i));
      @(negedge CLK);
      check_val("post_reset_err", {30'd0, CMD_ERR, REG_WrEn}, {30'd0, 2'b10});
      to_drv();
    end

    // random frames
    for (int n = 0; n < 80; n++) begin
      int kind = $urandom_range(0, 9);
      if (kind < 4) begin
        wr_frame(8'($urandom_range(0, 255)), 8'($urandom_range(0, 255)),
                 8'($urandom_range(0, 255)), 2);
      end else if (kind < 8) begin
        rd_frame(8'($urandom_range(0, 255)), ($urandom_range(0, 9) < 3));
      end else begin
        do b = 8'($urandom_range(0, 255)); while (b == 8'hAA || b == 8'hBB);
        exp_err++;
        send_byte(b);
      end
      idle_cycles($urandom_range(0, 1));
    end
    idle_cycles(4);

    check_val("err_count", obs_err, exp_err);
    check_val("wr_q_empty", exp_wr_q.size(), 0);
    check_val("rd_q_empty", exp_rd_q.size(), 0);
    check_val("tx_q_empty", exp_tx_q.size(), 0);
    check_val("final_idle", {31'd0, BUSY}, 32'd0);

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
    $finish;
  end

endmodule
